// File: rtl/client_meta_array_pkg.sv
// client_meta_array_pkg
//   Shared types, encodings and TileLink client-state transition functions
//   for the L1 data cache metadata array.
//   Optional feature macro: META_PARITY_EN adds an even-parity bit to every
//   stored entry (meta_entry_t.par).
package client_meta_array_pkg;

    // Stored tag width. The array's TAG_W parameter must not exceed it.
    localparam int META_TAG_W = 20;

    // Client coherence states
    localparam logic [1:0] ST_NOTHING = 2'd0;
    localparam logic [1:0] ST_BRANCH  = 2'd1;
    localparam logic [1:0] ST_TRUNK   = 2'd2;
    localparam logic [1:0] ST_DIRTY   = 2'd3;

    // Permission caps (grant / probe)
    localparam logic [1:0] CAP_TOT = 2'd0;
    localparam logic [1:0] CAP_TOB = 2'd1;
    localparam logic [1:0] CAP_TON = 2'd2;

    // Grow params
    localparam logic [1:0] GR_NTOB = 2'd0;
    localparam logic [1:0] GR_NTOT = 2'd1;
    localparam logic [1:0] GR_BTOT = 2'd2;

    // Shrink / report params
    localparam logic [2:0] SH_TTOB = 3'd0;
    localparam logic [2:0] SH_TTON = 3'd1;
    localparam logic [2:0] SH_BTON = 3'd2;
    localparam logic [2:0] SH_TTOT = 3'd3;
    localparam logic [2:0] SH_BTOB = 3'd4;
    localparam logic [2:0] SH_NTON = 3'd5;

    // Memory commands used by the transition functions
    localparam logic [4:0] M_XRD     = 5'h00;
    localparam logic [4:0] M_XWR     = 5'h01;
    localparam logic [4:0] M_PFW     = 5'h03;
    localparam logic [4:0] M_XA_SWAP = 5'h04;
    localparam logic [4:0] M_XLR     = 5'h06;
    localparam logic [4:0] M_XSC     = 5'h07;
    localparam logic [4:0] M_FLUSH   = 5'h10;
    localparam logic [4:0] M_PWR     = 5'h11;
    localparam logic [4:0] M_PRODUCE = 5'h12;
    localparam logic [4:0] M_CLEAN   = 5'h13;

    typedef enum logic [1:0] {
        K_ACCESS = 2'd0,
        K_GRANT  = 2'd1,
        K_PROBE  = 2'd2,
        K_CTRL   = 2'd3
    } meta_kind_e;

    typedef struct packed {
        logic [META_TAG_W-1:0] tag;
        logic [1:0]            state;
`ifdef META_PARITY_EN
        logic                  par;
`endif
    } meta_entry_t;

    typedef struct packed {
        logic       ok;
        logic [1:0] val;   // new state when ok, grow param otherwise
    } access_res_t;

    typedef struct packed {
        logic       data;
        logic [2:0] report;
        logic [1:0] state;
    } shrink_res_t;

    function automatic logic is_write(input logic [4:0] cmd);
        return (cmd == M_XWR) || (cmd == M_PWR) || (cmd == M_XSC) ||
               cmd[3] || (cmd == M_XA_SWAP);
    endfunction

    // {write, write-intent}: read=00, intent=01, write=11
    function automatic logic [1:0] categorize(input logic [4:0] cmd);
        logic wr;
        wr = is_write(cmd);
        return {wr, wr || (cmd == M_PFW) || (cmd == M_XLR)};
    endfunction

    function automatic access_res_t on_access(input logic [1:0] st, input logic [4:0] cmd);
        logic [1:0] c;
        c = categorize(cmd);
        if (st == ST_NOTHING)
            return '{ok: 1'b0, val: (c == 2'b00) ? GR_NTOB : GR_NTOT};
        if (st == ST_BRANCH)
            return (c == 2'b00) ? '{ok: 1'b1, val: ST_BRANCH} : '{ok: 1'b0, val: GR_BTOT};
        // Trunk or Dirty: a write dirties the line
        return '{ok: 1'b1, val: (c == 2'b11) ? ST_DIRTY : st};
    endfunction

    function automatic logic [1:0] miss_grow_param(input logic [4:0] cmd);
        return (categorize(cmd) == 2'b00) ? GR_NTOB : GR_NTOT;
    endfunction

    function automatic logic [1:0] on_grant(input logic [4:0] cmd, input logic [1:0] cap);
        logic [1:0] c;
        c = categorize(cmd);
        if (cap == CAP_TOT) return (c == 2'b11) ? ST_DIRTY : ST_TRUNK;
        if (cap == CAP_TOB && c == 2'b00) return ST_BRANCH;
        return ST_NOTHING;
    endfunction

    function automatic logic [1:0] cmd_to_perm_cap(input logic [4:0] cmd);
        case (cmd)
            M_PRODUCE: return CAP_TOB;
            M_CLEAN:   return CAP_TOT;
            default:   return CAP_TON;
        endcase
    endfunction

    function automatic shrink_res_t shrink_helper(input logic [1:0] cap, input logic [1:0] st);
        logic dirty;
        dirty = (st == ST_DIRTY);
        if (st == ST_NOTHING) return '{data: 1'b0, report: SH_NTON, state: ST_NOTHING};
        case (cap)
            CAP_TOT: return (st == ST_BRANCH) ? '{data: 1'b0, report: SH_BTOB, state: ST_BRANCH}
                                              : '{data: dirty, report: SH_TTOT, state: ST_TRUNK};
            CAP_TOB: return (st == ST_BRANCH) ? '{data: 1'b0, report: SH_BTOB, state: ST_BRANCH}
                                              : '{data: dirty, report: SH_TTOB, state: ST_BRANCH};
            CAP_TON: return (st == ST_BRANCH) ? '{data: 1'b0, report: SH_BTON, state: ST_NOTHING}
                                              : '{data: dirty, report: SH_TTON, state: ST_NOTHING};
            default: return '{data: 1'b0, report: 3'd0, state: ST_NOTHING};
        endcase
    endfunction

endpackage

// File: rtl/client_meta_victim.sv
// client_meta_victim
//   Victim way selection: lowest free (Nothing) way, otherwise a global
//   round-robin pointer that only advances when it supplies the victim.
//   Ports: clock, reset (async, active-high), free (per-way Nothing mask),
//   adv (pointer was used this cycle), vway (selected way), any_free.
module client_meta_victim #(
    parameter int NWAYS = 4,
    parameter int WAY_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NWAYS-1:0] free,
    input  logic             adv,
    output logic [WAY_W-1:0] vway,
    output logic             any_free
);

    logic [WAY_W-1:0] ptr;

    always_comb begin
        any_free = |free;
        vway     = ptr;
        for (int w = NWAYS - 1; w >= 0; w--) begin
            if (free[w]) vway = WAY_W'(w);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (adv) begin
            if (ptr == WAY_W'(NWAYS - 1)) ptr <= '0;
            else                          ptr <= ptr + WAY_W'(1);
        end
    end

endmodule

// File: rtl/client_meta_array.sv
// client_meta_array
//   Set-associative tag + client coherence-state array for the L1 D-cache.
//   Fixed 2-cycle pipeline: accept -> lookup/compute (s1) -> write + response.
//   Ports: clock/reset (async, active-high); init_done; req_* request channel
//   (valid/ready, kind, set, tag, way, cmd, param); resp_* one-cycle response
//   (hit, way, old/new state, param, dirty, perr).
//   Optional feature macro: META_PARITY_EN (even parity per entry; bad ways
//   are treated as Nothing and scrubbed). Without it resp_perr is tied 0.
module client_meta_array
    import client_meta_array_pkg::*;
#(
    parameter int NSETS = 64,
    parameter int NWAYS = 4,
    parameter int TAG_W = META_TAG_W,
    localparam int SET_W = $clog2(NSETS),
    localparam int WAY_W = (NWAYS > 1) ? $clog2(NWAYS) : 1
) (
    input  logic             clock,
    input  logic             reset,
    output logic             init_done,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_kind,
    input  logic [SET_W-1:0] req_set,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [WAY_W-1:0] req_way,
    input  logic [4:0]       req_cmd,
    input  logic [1:0]       req_param,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [WAY_W-1:0] resp_way,
    output logic [1:0]       resp_old_state,
    output logic [1:0]       resp_new_state,
    output logic [2:0]       resp_param,
    output logic             resp_dirty,
    output logic             resp_perr
);

    typedef enum logic {S_INIT, S_RUN} fsm_e;

    fsm_e             state_q, state_d;
    logic [SET_W-1:0] clr_ptr;
    logic             clr_wr;

    meta_entry_t mem [NSETS][NWAYS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            clr_ptr <= '0;
        end else begin
            state_q <= state_d;
            if (clr_wr) clr_ptr <= clr_ptr + SET_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        clr_wr  = 1'b0;
        case (state_q)
            S_INIT: begin
                clr_wr = 1'b1;
                if (clr_ptr == SET_W'(NSETS - 1)) state_d = S_RUN;
            end
            default: ;
        endcase
    end

    assign init_done = (state_q == S_RUN);
    assign req_ready = init_done;

    // ---- accept -> s1 ----
    logic             vld_p1;
    meta_kind_e       kind_p1;
    logic [SET_W-1:0] set_p1;
    logic [TAG_W-1:0] tag_p1;
    logic [WAY_W-1:0] way_p1;
    logic [4:0]       cmd_p1;
    logic [1:0]       param_p1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) vld_p1 <= 1'b0;
        else       vld_p1 <= req_valid && req_ready;
    end

    always_ff @(posedge clock) begin
        if (req_valid && req_ready) begin
            kind_p1  <= meta_kind_e'(req_kind);
            set_p1   <= req_set;
            tag_p1   <= req_tag;
            way_p1   <= req_way;
            cmd_p1   <= req_cmd;
            param_p1 <= req_param;
        end
    end

    // ---- s1: lookup and transition ----
    logic [META_TAG_W-1:0] tag_ext;
    meta_entry_t           row [NWAYS];
    logic [1:0]            eff_st [NWAYS];
    logic [NWAYS-1:0]      live, tmatch, hitv, perr;
    logic                  hit_any;
    logic [WAY_W-1:0]      hit_way, vway;
    logic                  any_free, adv;

    assign tag_ext = META_TAG_W'(tag_p1);

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < NWAYS; w++) begin
            row[w]    = mem[set_p1][w];
`ifdef META_PARITY_EN
            perr[w]   = ^{row[w].tag, row[w].state, row[w].par};
`else
            perr[w]   = 1'b0;
`endif
            // A parity-damaged way is indistinguishable from Nothing
            live[w]   = (row[w].state != ST_NOTHING) && !perr[w];
            eff_st[w] = live[w] ? row[w].state : ST_NOTHING;
            tmatch[w] = (row[w].tag == tag_ext);
            hitv[w]   = live[w] && tmatch[w];
        end
        for (int w = NWAYS - 1; w >= 0; w--) begin
            if (hitv[w]) hit_way = WAY_W'(w);
        end
        hit_any = |hitv;
    end

    client_meta_victim #(.NWAYS(NWAYS), .WAY_W(WAY_W)) u_victim (
        .clock    (clock),
        .reset    (reset),
        .free     (~live),
        .adv      (adv),
        .vway     (vway),
        .any_free (any_free)
    );

    logic             r_hit, r_dirty, r_perr, wr_en;
    logic [WAY_W-1:0] r_way;
    logic [1:0]       r_old, r_new, hit_st, cap;
    logic [2:0]       r_param;
    access_res_t      acc;
    shrink_res_t      sh;
    meta_entry_t      wr_ent;

    always_comb begin
        r_hit   = 1'b0;
        r_way   = '0;
        r_old   = ST_NOTHING;
        r_new   = ST_NOTHING;
        r_param = '0;
        r_dirty = 1'b0;
        wr_en   = 1'b0;
        adv     = 1'b0;
        hit_st  = eff_st[hit_way];
        acc     = on_access(hit_st, cmd_p1);
        cap     = (kind_p1 == K_PROBE) ? param_p1 : cmd_to_perm_cap(cmd_p1);
        sh      = shrink_helper(cap, hit_st);
        case (kind_p1)
            K_ACCESS: begin
                if (hit_any) begin
                    r_way = hit_way;
                    r_old = hit_st;
                    if (acc.ok) begin
                        r_hit = 1'b1;
                        r_new = acc.val;
                        wr_en = (acc.val != hit_st);
                    end else begin
                        r_new   = hit_st;
                        r_param = {1'b0, acc.val};
                    end
                end else begin
                    r_way   = vway;
                    r_old   = eff_st[vway];
                    r_new   = eff_st[vway];
                    r_param = {1'b0, miss_grow_param(cmd_p1)};
                    r_dirty = (eff_st[vway] == ST_DIRTY);
                    adv     = vld_p1 && !any_free;
                end
            end
            K_GRANT: begin
                r_hit = 1'b1;
                r_way = way_p1;
                r_old = eff_st[way_p1];
                r_new = on_grant(cmd_p1, param_p1);
                wr_en = 1'b1;
            end
            default: begin
                r_param = SH_NTON;
                if (hit_any) begin
                    r_hit   = 1'b1;
                    r_way   = hit_way;
                    r_old   = hit_st;
                    r_new   = sh.state;
                    r_param = sh.report;
                    r_dirty = sh.data;
                    wr_en   = 1'b1;
                end
            end
        endcase
`ifdef META_PARITY_EN
        r_perr = (|(perr & tmatch)) ? 1'b1 : perr[r_way];
`else
        r_perr = 1'b0;
`endif
        wr_ent.tag   = tag_ext;
        wr_ent.state = r_new;
`ifdef META_PARITY_EN
        wr_ent.par   = ^{tag_ext, r_new};
`endif
    end

    // ---- s1 -> array write and response ----
    always_ff @(posedge clock) begin
        for (int w = 0; w < NWAYS; w++) begin
            if (clr_wr) begin
                mem[clr_ptr][w] <= '0;
            end else if (vld_p1 && wr_en && r_way == WAY_W'(w)) begin
                mem[set_p1][w] <= wr_ent;
`ifdef META_PARITY_EN
            end else if (vld_p1 && perr[w]) begin
                mem[set_p1][w].state <= ST_NOTHING;
                mem[set_p1][w].par   <= ^row[w].tag;
`endif
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_way       <= '0;
            resp_old_state <= '0;
            resp_new_state <= '0;
            resp_param     <= '0;
            resp_dirty     <= 1'b0;
            resp_perr      <= 1'b0;
        end else begin
            resp_valid     <= vld_p1;
            resp_hit       <= r_hit;
            resp_way       <= r_way;
            resp_old_state <= r_old;
            resp_new_state <= r_new;
            resp_param     <= r_param;
            resp_dirty     <= r_dirty;
            resp_perr      <= r_perr;
        end
    end

endmodule

// File: tb/tb_client_meta_array.sv
module tb_client_meta_array;

    localparam logic [1:0] KA = 2'd0, KG = 2'd1, KP = 2'd2, KC = 2'd3;
    localparam int NOTH = 0, BRAN = 1, TRUN = 2, DIRT = 3;
    localparam int TOT = 0, TOB = 1, TON = 2;
    localparam int NTOB = 0, BTOT = 2;
    localparam int TTOB = 0, TTON = 1, BTON = 2, NTON = 5;
    localparam int XRD = 0, XWR = 1, FLUSH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        init_done, req_ready;
    logic        req_valid = 1'b0;
    logic [1:0]  req_kind = '0;
    logic [5:0]  req_set = '0;
    logic [19:0] req_tag = '0;
    logic [1:0]  req_way = '0;
    logic [4:0]  req_cmd = '0;
    logic [1:0]  req_param = '0;
    logic        resp_valid, resp_hit, resp_dirty, resp_perr;
    logic [1:0]  resp_way, resp_old_state, resp_new_state;
    logic [2:0]  resp_param;

    int n_checks = 0;
    int n_errors = 0;
    int cnt;

    always #5 clock = ~clock;

    client_meta_array dut (
        .clock          (clock),
        .reset          (reset),
        .init_done      (init_done),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_kind       (req_kind),
        .req_set        (req_set),
        .req_tag        (req_tag),
        .req_way        (req_way),
        .req_cmd        (req_cmd),
        .req_param      (req_param),
        .resp_valid     (resp_valid),
        .resp_hit       (resp_hit),
        .resp_way       (resp_way),
        .resp_old_state (resp_old_state),
        .resp_new_state (resp_new_state),
        .resp_param     (resp_param),
        .resp_dirty     (resp_dirty),
        .resp_perr      (resp_perr)
    );

    task automatic check_eq(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] k, input int set, input int tag, input int way,
                         input int cmd, input int prm);
        logic [31:0] s, t, w, c, p;
        s = set; t = tag; w = way; c = cmd; p = prm;
        req_valid = 1'b1;
        req_kind  = k;
        req_set   = s[5:0];
        req_tag   = t[19:0];
        req_way   = w[1:0];
        req_cmd   = c[4:0];
        req_param = p[1:0];
    endtask

    // Issue one request alone and stop on the negedge where its response is valid
    task automatic send(input logic [1:0] k, input int set, input int tag, input int way,
                        input int cmd, input int prm);
        @(negedge clock);
        drive(k, set, tag, way, cmd, prm);
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        check_eq("resp_valid", {31'd0, resp_valid}, 1);
    endtask

    task automatic expect_resp(input string nm, input int hit, input int way, input int old_st,
                               input int new_st, input int prm, input int dirty);
        check_eq({nm, ".hit"},   {31'd0, resp_hit}, hit);
        check_eq({nm, ".way"},   {30'd0, resp_way}, way);
        check_eq({nm, ".old"},   {30'd0, resp_old_state}, old_st);
        check_eq({nm, ".new"},   {30'd0, resp_new_state}, new_st);
        check_eq({nm, ".param"}, {29'd0, resp_param}, prm);
        check_eq({nm, ".dirty"}, {31'd0, resp_dirty}, dirty);
    endtask

    task automatic wait_init(input string nm);
        cnt = 0;
        while (!init_done && cnt < 200) begin
            @(posedge clock);
            cnt++;
            #1;
        end
        check_eq(nm, cnt, 64);
    endtask

    initial begin
        // Reset state: every output low
        #12;
        check_eq("rst.init_done", {31'd0, init_done}, 0);
        check_eq("rst.req_ready", {31'd0, req_ready}, 0);
        check_eq("rst.resp_valid", {31'd0, resp_valid}, 0);
        check_eq("rst.resp_bits", {19'd0, resp_hit, resp_way, resp_old_state, resp_new_state,
                                   resp_param, resp_dirty, resp_perr}, 0);
        @(negedge clock);
        reset = 1'b0;
        wait_init("init_cycles");
        check_eq("run.req_ready", {31'd0, req_ready}, 1);

        // Cleared array: nothing hits, victim is way 0
        send(KP, 0, 0, 0, XRD, TON);
        expect_resp("clr_s0", 0, 0, NOTH, NOTH, NTON, 0);
        send(KP, 63, 0, 0, XRD, TON);
        expect_resp("clr_s63", 0, 0, NOTH, NOTH, NTON, 0);
        send(KA, 31, 0, 0, XRD, 0);
        expect_resp("clr_acc", 0, 0, NOTH, NOTH, NTOB, 0);
        check_eq("perr_off", {31'd0, resp_perr}, 0);
        @(negedge clock);
        check_eq("resp_pulse", {31'd0, resp_valid}, 0);

        // Grant read/toB -> Branch; write access on Branch needs BtoT
        send(KG, 5, 'h123, 2, XRD, TOB);
        expect_resp("grant_b", 1, 2, NOTH, BRAN, 0, 0);
        send(KA, 5, 'h123, 0, XWR, 0);
        expect_resp("acc_btot", 0, 2, BRAN, BRAN, BTOT, 0);
        send(KA, 5, 'h123, 0, XRD, 0);
        expect_resp("acc_rd_b", 1, 2, BRAN, BRAN, 0, 0);

        // Grant write/toT -> Dirty, then back-to-back probes toB and toN
        send(KG, 5, 'h123, 2, XWR, TOT);
        expect_resp("grant_d", 1, 2, BRAN, DIRT, 0, 0);
        @(negedge clock);
        drive(KP, 5, 'h123, 0, XRD, TOB);
        @(negedge clock);
        drive(KP, 5, 'h123, 0, XRD, TON);
        @(negedge clock);
        req_valid = 1'b0;
        check_eq("pr1.valid", {31'd0, resp_valid}, 1);
        expect_resp("probe_tob", 1, 2, DIRT, BRAN, TTOB, 1);
        @(negedge clock);
        check_eq("pr2.valid", {31'd0, resp_valid}, 1);
        expect_resp("probe_ton", 1, 2, BRAN, NOTH, BTON, 0);
        send(KA, 5, 'h123, 0, XRD, 0);
        expect_resp("acc_gone", 0, 0, NOTH, NOTH, NTOB, 0);

        // Full set: round-robin victim 0,1,2,3,0
        for (int w = 0; w < 4; w++) begin
            send(KG, 7, 'h10 + w, w, XRD, TOT);
            expect_resp("fill", 1, w, NOTH, TRUN, 0, 0);
        end
        for (int i = 0; i < 5; i++) begin
            send(KA, 7, 'h99, 0, XRD, 0);
            expect_resp("rr", 0, i % 4, TRUN, TRUN, NTOB, 0);
        end
        send(KP, 7, 'h11, 0, XRD, TON);
        expect_resp("probe_w1", 1, 1, TRUN, NOTH, TTON, 0);
        send(KA, 7, 'h99, 0, XRD, 0);
        expect_resp("free_w1", 0, 1, NOTH, NOTH, NTOB, 0);

        // Write hit on Trunk dirties it; flush reports data
        send(KA, 7, 'h10, 0, XWR, 0);
        expect_resp("acc_wr_t", 1, 0, TRUN, DIRT, 0, 0);
        send(KC, 7, 'h10, 0, FLUSH, 0);
        expect_resp("flush", 1, 0, DIRT, NOTH, TTON, 1);
        send(KC, 7, 'h10, 0, FLUSH, 0);
        expect_resp("flush_miss", 0, 0, NOTH, NOTH, NTON, 0);

        // Reset just after a request is accepted
        @(negedge clock);
        drive(KG, 9, 'h77, 1, XRD, TOT);
        @(posedge clock);
        #2;
        reset = 1'b1;
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq("mid_rst.valid", {31'd0, resp_valid}, 0);
            check_eq("mid_rst.init", {31'd0, init_done}, 0);
        end
        reset = 1'b0;
        wait_init("reinit_cycles");
        send(KA, 7, 'h12, 0, XRD, 0);
        expect_resp("reinit_s7", 0, 0, NOTH, NOTH, NTOB, 0);
        send(KP, 9, 'h77, 0, XRD, TON);
        expect_resp("reinit_s9", 0, 0, NOTH, NOTH, NTON, 0);

`ifdef META_PARITY_EN
        send(KG, 3, 'h55, 0, XRD, TOT);
        expect_resp("par_grant", 1, 0, NOTH, TRUN, 0, 0);
        @(negedge clock);
        dut.mem[3][0].tag[0] = ~dut.mem[3][0].tag[0];
        send(KA, 3, 'h55, 0, XRD, 0);
        expect_resp("par_acc", 0, 0, NOTH, NOTH, NTOB, 0);
        check_eq("par_perr", {31'd0, resp_perr}, 1);
        send(KA, 3, 'h55, 0, XRD, 0);
        check_eq("par_scrubbed", {31'd0, resp_perr}, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
